ham_secded_dec_pipe: RTL

//  Parametrised SECDED Hamming decoder. Next generation of the 12-bit SEC decoder.

---
 rtl/ham_secded_dec_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ham_secded_dec_pipe.sv
// rtl/ham_secded_dec_pipe.sv - two-stage SECDED Hamming decoder with handshake and saturating error counters
module ham_secded_dec_pipe #(
    parameter int DATA_W = 12,
    parameter int PAR_W  = 5,
    parameter int CNT_W  = 16,
    localparam int N     = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      codeword_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_sgl,
    output logic              err_dbl,
    output logic [PAR_W-1:0]  err_pos,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    if ((2 ** PAR_W) < N) begin : g_par_check
        $error("PAR_W too small to address every codeword position");
    end

    logic              adv;
    logic [PAR_W-1:0]  syn_c;
    logic              p_c;
    logic              s1_valid;
    logic [N-1:0]      s1_cw;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_p;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] dec_data;
    logic              dec_sgl;
    logic              dec_dbl;
    logic [PAR_W-1:0]  dec_pos;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign p_c      = ^codeword_in;

    // Bit i carries Hamming position i+1; the overall parity bit is excluded from the syndrome.
    always_comb begin
        syn_c = '0;
        for (int i = 0; i < N - 1; i++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if ((((i + 1) >> k) % 2) == 1) begin
                    syn_c[k] = syn_c[k] ^ codeword_in[i];
                end
            end
        end
    end

    always_comb begin
        fixed    = s1_cw;
        dec_sgl  = 1'b0;
        dec_dbl  = 1'b0;
        dec_pos  = '0;
        dec_data = '0;
        if (s1_syn == '0) begin
            dec_sgl = s1_p;
        end else if (!s1_p || (int'(s1_syn) > N - 1)) begin
            dec_dbl = 1'b1;
        end else begin
            dec_sgl = 1'b1;
            dec_pos = s1_syn;
            for (int i = 0; i < N - 1; i++) begin
                if (int'(s1_syn) == i + 1) begin
                    fixed[i] = ~fixed[i];
                end
            end
        end
        // Data occupies the non-power-of-two positions in ascending order.
        begin
            int j;
            j = 0;
            for (int pos = 1; pos < N; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    if (j < DATA_W) begin
                        dec_data[j] = fixed[pos-1];
                    end
                    j++;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_cw     <= '0;
            s1_syn    <= '0;
            s1_p      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            err_sgl   <= 1'b0;
            err_dbl   <= 1'b0;
            err_pos   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_cw     <= codeword_in;
            s1_syn    <= syn_c;
            s1_p      <= p_c;
            out_valid <= s1_valid;
            data_out  <= dec_data;
            err_sgl   <= dec_sgl;
            err_dbl   <= dec_dbl;
            err_pos   <= dec_pos;
        end
    end

    // Counting on the output handshake ensures a stalled result is counted once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_valid && out_ready) begin
            if (err_sgl && (cnt_corr != {CNT_W{1'b1}})) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (err_dbl && (cnt_uncorr != {CNT_W{1'b1}})) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule
